// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared constants and state encoding for the fetch-side PC
//               redirect controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  // Architectural address width and default reset vector
  localparam int unsigned ADDR_W           = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Sequential fetch increment (one 32-bit instruction)
  localparam int unsigned PC_INC = 4;

  // Redirect controller states
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,  // first cycle after reset release, fetch not yet valid
    ST_RUN  = 2'd1,  // normal fetch
    ST_PEND = 2'd2   // branch arrived during a stall, waiting to apply it
  } state_e;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/pc_redirect_ctrl_pc.sv
`default_nettype none
// ============================================================================
// Module      : ProgramCounter
// Description : WIDTH-bit program counter register with load enable and
//               asynchronous active-low reset to RESET_PC.
// Revision    : 1.0 - initial release
// ============================================================================
module ProgramCounter #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] pc_d_i,
  output logic [WIDTH-1:0] pc_o
);

  logic [WIDTH-1:0] pc_q;

  // PC register: reload only when the controller asks for it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= RESET_PC;
    end else if (load_i) begin
      pc_q <= pc_d_i;
    end
  end

  assign pc_o = pc_q;

endmodule : ProgramCounter
`default_nettype wire

// File: rtl/pc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_redirect_ctrl
// Description : Owns the fetch PC. Applies taken branches (priority) and
//               jumps, holds a branch that arrives during a stall until the
//               stall drops, drives the IF/ID flush and counts redirects.
//               Optional macro BRANCH_DELAY_SLOT_EN: flush suppressed so the
//               delay-slot instruction proceeds; PC behaviour is unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_redirect_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned      WIDTH     = ADDR_W,
  parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(DEFAULT_RESET_PC),
  parameter int unsigned      CNT_WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Stall,
  input  logic                 PCSrc,
  input  logic [WIDTH-1:0]     BranchTarget,
  input  logic                 Jump,
  input  logic [WIDTH-1:0]     JumpTarget,
  output logic [WIDTH-1:0]     PC,
  output logic [WIDTH-1:0]     PCPlus4,
  output logic                 Flush_IFID,
  output logic                 FetchValid,
  output logic [CNT_WIDTH-1:0] RedirectCount
);

  // Targets are word aligned: the two low bits are dropped before use
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(3));

  state_e               state_q;
  logic [WIDTH-1:0]     pend_q;
  logic                 fetch_valid_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic [WIDTH-1:0]     pc_d;
  logic                 pc_load;
  logic                 redirect;
  logic [WIDTH-1:0]     branch_tgt;
  logic [WIDTH-1:0]     jump_tgt;

  assign branch_tgt = BranchTarget & ALIGN_MASK;
  assign jump_tgt   = JumpTarget & ALIGN_MASK;
  assign PCPlus4    = PC + WIDTH'(PC_INC);

  // Next-PC select: pending branch, then taken branch, then jump, then PC+4
  always_comb begin
    pc_load  = 1'b0;
    pc_d     = PC;
    redirect = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (!Stall) begin
          pc_load = 1'b1;
          if (PCSrc) begin
            pc_d     = branch_tgt;
            redirect = 1'b1;
          end else if (Jump) begin
            pc_d     = jump_tgt;
            redirect = 1'b1;
          end else begin
            pc_d = PCPlus4;
          end
        end
      end
      ST_PEND: begin
        if (!Stall) begin
          pc_load  = 1'b1;
          pc_d     = pend_q;
          redirect = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Controller FSM with pending-target capture and saturating redirect count
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q       <= ST_BOOT;
      pend_q        <= '0;
      fetch_valid_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_q       <= ST_RUN;
          fetch_valid_q <= 1'b1;
        end
        ST_RUN: begin
          // A stalled jump is dropped; the hazard unit re-presents it
          if (Stall && PCSrc) begin
            pend_q  <= branch_tgt;
            state_q <= ST_PEND;
          end
        end
        ST_PEND: begin
          // Older branch wins: new PCSrc/Jump ignored until it is applied
          if (!Stall) begin
            state_q <= ST_RUN;
          end
        end
        default: state_q <= ST_BOOT;
      endcase
      if (redirect && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
    end
  end

`ifdef BRANCH_DELAY_SLOT_EN
  // Delay-slot instruction in IF/ID always executes
  assign Flush_IFID = 1'b0;
`else
  assign Flush_IFID = redirect;
`endif

  assign FetchValid    = fetch_valid_q;
  assign RedirectCount = cnt_q;

  ProgramCounter #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk_i  (Clk),
    .rst_ni (Rst_n),
    .load_i (pc_load),
    .pc_d_i (pc_d),
    .pc_o   (PC)
  );

endmodule : pc_redirect_ctrl
`default_nettype wire

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Fetch-side responder for the branch-decision signal: consumes the taken-branch strobe (Branch AND Zero) and jump requests from later pipeline stages, owns the program counter, and redirects fetch. Generates the IF/ID flush, holds redirects that arrive during a hazard stall until they can be applied, and counts applied redirects for performance debug. Sits between the hazard unit, the EX-stage branch logic and instruction memory.

## Interface
- WIDTH, 32, PC and target width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CNT_WIDTH, 16, redirect counter width
- Clk  input  1  pipeline clock, rising edge
- Rst_n  input  1  asynchronous, active-low reset
- Stall  input  1  hazard-unit stall; PC and state frozen while high
- PCSrc  input  1  branch taken (Branch & Zero) from EX stage
- BranchTarget  input  WIDTH  branch target address from EX stage
- Jump  input  1  jump decoded in ID stage
- JumpTarget  input  WIDTH  jump target address from ID stage
- PC  output  WIDTH  current fetch address
- PCPlus4  output  WIDTH  PC + 4, combinational
- Flush_IFID  output  1  clears IF/ID register at the next edge
- FetchValid  output  1  instruction at PC is valid
- RedirectCount  output  CNT_WIDTH  applied redirects, saturating

## Operation
- States: BOOT, RUN, PEND.
- Reset (Rst_n low, any time, mid-pending included): PC=RESET_PC, state=BOOT, pending target cleared, FetchValid=0, Flush_IFID=0, RedirectCount=0.
- BOOT: one cycle, PC held; next edge -> RUN, FetchValid=1 from then on.
- RUN, Stall=0: priority PCSrc > Jump > sequential. PCSrc: PC<=BranchTarget. Else Jump: PC<=JumpTarget. Else PC<=PC+4.
- RUN, Stall=1, PCSrc=1: BranchTarget latched into pending register, PC held, -> PEND. Stall=1 without PCSrc: PC held; Jump ignored (hazard unit re-presents it).
- PEND: Stall=1 holds; PCSrc/Jump ignored (older branch wins). Stall=0: PC<=pending target, -> RUN.
- Targets: bits [1:0] forced to 0 before loading PC.
- Flush_IFID: combinational, high in any cycle a redirect is applied at the coming edge (branch or jump in RUN with Stall=0, or PEND exit); never high while Stall=1.
- RedirectCount: +1 per applied redirect (same edge as PC load); saturates at all-ones, no wrap.
- PC+4 wraps modulo 2^WIDTH.

## Timing
- Redirect latency: PCSrc sampled at edge N -> PC=target after edge N, fetch of target in cycle N+1.
- Stalled redirect: applied at the first edge with Stall=0; latency = stall length + 1.
- Flush_IFID and PC load occur on the same edge; no bubble beyond the flushed slot.
- FetchValid low only in BOOT (first cycle after reset release).
- All state changes on rising Clk; outputs other than Flush_IFID and PCPlus4 are registered.

## Configuration
- BRANCH_DELAY_SLOT_EN defined: Flush_IFID held 0 for all redirects; delay-slot instruction in IF/ID proceeds. PC behaviour unchanged.
- Not defined: Flush_IFID behaves as above (no delay slot).

## Structure
- Shared package mips_pkg: state encoding (BOOT/RUN/PEND), PC_INC=4, default RESET_PC, address width constant.
- One sub-module: ProgramCounter (WIDTH-bit register with async active-low reset to RESET_PC, load enable, next-value input); FSM, priority select and counter stay in the top.

## Test plan
- Reset release, no stall, 4 cycles -> FetchValid 0 then 1; PC 0x0, 0x0, 0x4, 0x8.
- PCSrc=1, BranchTarget=0x100, Jump=1, JumpTarget=0x200 same cycle, Stall=0 -> PC=0x100 next cycle, Flush_IFID=1 that cycle, RedirectCount=1.
- PCSrc=1 with Stall=1 for 3 cycles, BranchTarget changes to 0x300 after first -> PC held 3 cycles, Flush_IFID=0, then PC=first target, Flush_IFID=1 on release cycle.
- Rst_n low while in PEND -> PC=RESET_PC immediately, pending discarded, count=0.
- BranchTarget=0x103 -> PC=0x100; RedirectCount preloaded near max with CNT_WIDTH=4, 20 redirects -> stays 0xF.
- Build with BRANCH_DELAY_SLOT_EN, taken branch -> PC redirects, Flush_IFID stays 0.
